vga_fb_arbiter: RTL

- Shares one single-port framebuffer RAM (RGB332, one byte per pixel) between two requesters: the VGA pixel fetch path and the CPU load/store path.
- The VGA fetch has absolute priority. It issues at most one read per pixel-enable pulse (one every 4 pixel clocks), so the CPU gets the remaining slots.
- Sits between the VGA timing/colour pipeline, the CPU memory-mapped bus and the framebuffer BRAM.
- Tags every memory access with its owner and routes read data back with a fixed latency.

---
 rtl/vga_fb_pkg.sv | 39 +++
 rtl/vga_fb_tag_pipe.sv | 39 +++
 rtl/vga_fb_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/vga_fb_pkg.sv
// Shared definitions for the framebuffer arbiter and the colour pipeline.
//   - Framebuffer geometry and bus widths.
//   - Owner tag attached to every framebuffer access.
//   - RGB332 field positions and extraction helpers.
package vga_fb_pkg;

  localparam int ADDR_W   = 19;
  localparam int DATA_W   = 8;
  localparam int FB_DEPTH = 640 * 480;

  // Who is waiting for the data of an access issued to the RAM.
  // CPU writes and empty slots both carry TAG_NONE.
  typedef enum logic [1:0] {
    TAG_NONE   = 2'd0,
    TAG_VGA    = 2'd1,
    TAG_CPU_RD = 2'd2
  } owner_tag_t;

  // RGB332 layout: RRR GGG BB
  localparam int RGB_R_MSB = 7;
  localparam int RGB_R_LSB = 5;
  localparam int RGB_G_MSB = 4;
  localparam int RGB_G_LSB = 2;
  localparam int RGB_B_MSB = 1;
  localparam int RGB_B_LSB = 0;

  function automatic logic [2:0] rgb332_red(input logic [DATA_W-1:0] pix);
    return pix[RGB_R_MSB:RGB_R_LSB];
  endfunction

  function automatic logic [2:0] rgb332_green(input logic [DATA_W-1:0] pix);
    return pix[RGB_G_MSB:RGB_G_LSB];
  endfunction

  function automatic logic [1:0] rgb332_blue(input logic [DATA_W-1:0] pix);
    return pix[RGB_B_MSB:RGB_B_LSB];
  endfunction

endpackage

// File: rtl/vga_fb_tag_pipe.sv
// Two-stage owner-tag / range-error shift register.
// Stage 1 lines up with the RAM issue cycle, stage 2 with the RAM read data.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   tag_in       owner of the access granted this cycle
//   err_in       access granted this cycle was out of range
//   err_issue    range error, issue stage
//   tag_ret      owner, return stage
//   err_ret      range error, return stage
module vga_fb_tag_pipe
  import vga_fb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  owner_tag_t tag_in,
  input  logic       err_in,
  output logic       err_issue,
  output owner_tag_t tag_ret,
  output logic       err_ret
);

  owner_tag_t tag_issue;

  // Reset empties both slots so nothing in flight can produce an rvalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_issue <= TAG_NONE;
      err_issue <= 1'b0;
      tag_ret   <= TAG_NONE;
      err_ret   <= 1'b0;
    end else begin
      tag_issue <= tag_in;
      err_issue <= err_in;
      tag_ret   <= tag_issue;
      err_ret   <= err_issue;
    end
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Shares one single-port framebuffer RAM between the VGA pixel fetch and the
// CPU load/store bus. VGA has absolute priority; both paths see a fixed
// two-cycle read latency and back-to-back accesses pipeline at one per cycle.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   pix_req, pix_addr             VGA fetch request (single-cycle pulse)
//   pix_rvalid, pix_rdata         VGA read return
//   cpu_valid, cpu_ready          CPU request handshake
//   cpu_we, cpu_addr, cpu_wdata   CPU request payload
//   cpu_rvalid, cpu_rdata         CPU read return
//   cpu_err                       pulse when an out-of-range CPU access is accepted
//   mem_en, mem_we, mem_addr,
//   mem_wdata, mem_rdata          framebuffer RAM port (read data one cycle after mem_en)
//   stall_cnt, stall_clr          saturating CPU stall counter and its synchronous clear
module vga_fb_arbiter
  import vga_fb_pkg::*;
#(
  parameter int ADDR_W   = vga_fb_pkg::ADDR_W,
  parameter int FB_DEPTH = vga_fb_pkg::FB_DEPTH,
  parameter int DATA_W   = vga_fb_pkg::DATA_W,
  parameter int STALL_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pix_req,
  input  logic [ADDR_W-1:0]  pix_addr,
  output logic               pix_rvalid,
  output logic [DATA_W-1:0]  pix_rdata,
  input  logic               cpu_valid,
  output logic               cpu_ready,
  input  logic               cpu_we,
  input  logic [ADDR_W-1:0]  cpu_addr,
  input  logic [DATA_W-1:0]  cpu_wdata,
  output logic               cpu_rvalid,
  output logic [DATA_W-1:0]  cpu_rdata,
  output logic               cpu_err,
  output logic               mem_en,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic [STALL_W-1:0] stall_cnt,
  input  logic               stall_clr
);

  localparam logic [ADDR_W-1:0] FB_LIMIT = ADDR_W'(FB_DEPTH);

  logic              cpu_oor;
  logic              issue_en;
  logic              issue_we;
  logic [ADDR_W-1:0] issue_addr;
  logic [DATA_W-1:0] issue_wdata;
  owner_tag_t        issue_tag;
  logic              issue_err;

  owner_tag_t        ret_tag;
  logic              ret_err;
  logic [DATA_W-1:0] pix_rdata_q;
  logic [DATA_W-1:0] cpu_rdata_q;

  // Arbitration: VGA always wins. An out-of-range CPU access is still
  // accepted so the bus never hangs, but it never reaches the RAM; the VGA
  // address is trusted and never range-checked.
  always_comb begin
    cpu_ready   = cpu_valid & ~pix_req;
    cpu_oor     = (cpu_addr >= FB_LIMIT);
    issue_en    = 1'b0;
    issue_we    = 1'b0;
    issue_addr  = '0;
    issue_wdata = '0;
    issue_tag   = TAG_NONE;
    issue_err   = 1'b0;
    if (pix_req) begin
      issue_en   = 1'b1;
      issue_addr = pix_addr;
      issue_tag  = TAG_VGA;
    end else if (cpu_valid) begin
      issue_err = cpu_oor;
      issue_tag = cpu_we ? TAG_NONE : TAG_CPU_RD;
      if (!cpu_oor) begin
        issue_en    = 1'b1;
        issue_we    = cpu_we;
        issue_addr  = cpu_addr;
        issue_wdata = cpu_we ? cpu_wdata : '0;
      end
    end
  end

  // Issue stage: the RAM port is registered from the winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en    <= issue_en;
      mem_we    <= issue_we;
      mem_addr  <= issue_addr;
      mem_wdata <= issue_wdata;
    end
  end

  vga_fb_tag_pipe u_tag_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .tag_in    (issue_tag),
    .err_in    (issue_err),
    .err_issue (cpu_err),
    .tag_ret   (ret_tag),
    .err_ret   (ret_err)
  );

  // Return stage: RAM data goes straight through to its owner in the cycle
  // it arrives; otherwise each rdata output replays its last returned value.
  // An out-of-range read never touched the RAM, so it returns zero.
  always_comb begin
    pix_rvalid = (ret_tag == TAG_VGA);
    cpu_rvalid = (ret_tag == TAG_CPU_RD);
    pix_rdata  = pix_rvalid ? mem_rdata : pix_rdata_q;
    cpu_rdata  = cpu_rdata_q;
    if (cpu_rvalid) begin
      cpu_rdata = ret_err ? '0 : mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_rdata_q <= '0;
      cpu_rdata_q <= '0;
    end else begin
      if (pix_rvalid) begin
        pix_rdata_q <= pix_rdata;
      end
      if (cpu_rvalid) begin
        cpu_rdata_q <= cpu_rdata;
      end
    end
  end

  // Stall counter: clear beats increment, and it sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall_clr) begin
      stall_cnt <= '0;
    end else if (cpu_valid && !cpu_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
